// File: rtl/uart_tx_sb_ctrl.sv
// uart_tx_sb_ctrl: bus-mapped UART transmitter, 8 data bits LSB-first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to add the PARITY_EN register and an even parity bit.
module uart_tx_sb_ctrl #(
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 87
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        write_enable_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam logic [23:0] A_DATA = 24'h00;
    localparam logic [23:0] A_BUSY = 24'h08;
    localparam logic [23:0] A_DIV  = 24'h0C;
    localparam logic [23:0] A_PAR  = 24'h10;
    localparam logic [23:0] A_STOP = 24'h14;
    localparam logic [23:0] A_RST  = 24'h24;

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_stop2;
    logic             r_stop_idx;
    logic             r_tx;
    logic             r_busy;
    logic [31:0]      r_rdata;
`ifdef UART_TX_PARITY_EN
    logic             r_par_en;
    logic             r_parity;
`endif

    logic [23:0] w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_data;
    logic        w_soft;
    logic        w_cfg_ok;
    logic        w_tick;
    logic        w_last_stop;
    logic        w_par_en;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_off       = addr_i[23:0];
    assign w_wr        = req_i & write_enable_i;
    assign w_rd        = req_i & ~write_enable_i;
    assign w_wr_data   = w_wr && (w_off == A_DATA);
    assign w_soft      = w_wr && (w_off == A_RST) && (write_data_i == 32'd1);
    assign w_cfg_ok    = w_wr & ~r_busy;
    assign w_tick      = (r_cnt == (r_div - DIV_ONE));
    assign w_last_stop = (r_stop_idx == r_stop2);
    assign w_unused    = ^addr_i[31:24];

`ifdef UART_TX_PARITY_EN
    assign w_par_en = r_par_en;
`else
    assign w_par_en = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'd0;
        unique case (w_off)
            A_BUSY:  w_rdata = {31'd0, r_busy};
            A_DIV:   w_rdata = {{(32-DIV_W){1'b0}}, r_div};
            A_PAR:   w_rdata = {31'd0, w_par_en};
            A_STOP:  w_rdata = {30'd0, r_stop2 ? 2'd2 : 2'd1};
            default: w_rdata = 32'd0;
        endcase
    end

    // Soft reset mirrors the asynchronous reset branch exactly.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_INIT;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_shift    <= 8'd0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_rdata    <= 32'd0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
`endif
        end else if (w_soft) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_INIT;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_shift    <= 8'd0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_rdata    <= 32'd0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
`endif
        end else begin
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
            if (w_cfg_ok && (w_off == A_DIV)) begin
                if (write_data_i[DIV_W-1:0] == '0) begin
                    r_div <= DIV_ONE;
                end else begin
                    r_div <= write_data_i[DIV_W-1:0];
                end
            end
`ifdef UART_TX_PARITY_EN
            if (w_cfg_ok && (w_off == A_PAR)) begin
                r_par_en <= write_data_i[0];
            end
`endif
            if (w_cfg_ok && (w_off == A_STOP)) begin
                r_stop2 <= (write_data_i[1:0] == 2'd2);
            end
            if (r_state != S_IDLE) begin
                r_cnt <= w_tick ? '0 : r_cnt + DIV_ONE;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_wr_data) begin
                        r_shift  <= write_data_i[7:0];
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^write_data_i[7:0];
`endif
                        r_cnt    <= '0;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_idx   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= S_STOP;
                            end
`else
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= S_STOP;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign read_data_o = r_rdata;
    assign tx_o        = r_tx;
    assign busy_o      = r_busy;

endmodule
